button_debounce: RTL and testbench

- Conditions a raw, bouncy, asynchronous pushbutton input into a clean, clock-synchronous level, plus single-cycle event pulses.
- Sits directly upstream of the button-to-LED stage. That stage takes PRESSED or TOGGLE as its BUTTON input.
- Also provides press, release and long-press event pulses for downstream game/control logic.

---
 rtl/button_debounce.sv | 145 ++++++++++++++
 tb/tb_button_debounce.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, debounce FSM and event pulses
// (press, release, long press) plus a toggle level for LED drive.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BUTTON,
    output logic PRESSED,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG_PRESS,
    output logic TOGGLE
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);

    typedef enum logic [1:0] {IDLE, ARMING, HELD, DISARMING} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] long_q, long_d;
    logic          sync1_q, sync2_q;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_press_q, long_press_d;
    logic          toggle_q, toggle_d;
    logic          sync;
    logic          accept_press;
    logic          accept_release;

    assign sync = sync2_q ^ ACTIVE_LOW;

    assign accept_press   = (state_q == ARMING) && sync && (cnt_q == DB_LAST);
    assign accept_release = (state_q == DISARMING) && !sync && (cnt_q == DB_LAST);

    // Synchroniser flops reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q      <= ACTIVE_LOW;
            sync2_q      <= ACTIVE_LOW;
            state_q      <= IDLE;
            cnt_q        <= '0;
            long_q       <= '0;
            pressed_q    <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;
            toggle_q     <= 1'b0;
        end else begin
            sync1_q      <= BUTTON;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            long_q       <= long_d;
            pressed_q    <= pressed_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_press_q <= long_press_d;
            toggle_q     <= toggle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = ARMING;
                    cnt_d   = DW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ARMING: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_d = DISARMING;
                    cnt_d   = DW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            DISARMING: begin
                if (sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Long counter runs while the debounced level is high and parks at LONG_CYCLES.
    always_comb begin
        pressed_d    = pressed_q;
        press_d      = accept_press;
        release_d    = accept_release;
        toggle_d     = toggle_q ^ accept_press;
        long_press_d = pressed_q && (long_q == LONG_LAST);
        long_d       = long_q;
        if (accept_press) begin
            pressed_d = 1'b1;
        end else if (accept_release) begin
            pressed_d = 1'b0;
        end
        if (accept_press || accept_release) begin
            long_d = '0;
        end else if (pressed_q && (long_q != LONG_MAX)) begin
            long_d = long_q + 1'b1;
        end
    end

    assign PRESSED    = pressed_q;
    assign PRESS      = press_q;
    assign RELEASE    = release_q;
    assign LONG_PRESS = long_press_q;
    assign TOGGLE     = toggle_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: a window-based reference model pushes
// expected outputs per edge, a monitor pops and compares them #1 after the edge.
module tb_button_debounce;
    localparam int D = 4;
    localparam int L = 20;
    localparam int NSEG = 25;
    localparam int NSCEN = 5;

    typedef struct {
        logic pressed;
        logic press;
        logic rel;
        logic lng;
        logic tog;
    } exp_t;

    typedef struct {
        int   scen;
        logic lvl;
        int   n;
    } seg_t;

    typedef struct {
        int first_press;
        int first_rel;
        int first_long;
        int n_press;
        int n_rel;
        int n_long;
        bit use1;
    } scen_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic button0 = 1'b0;
    logic button1 = 1'b1;
    logic p0, ps0, r0, l0, t0;
    logic p1, ps1, r1, l1, t1;
    logic act_pressed, act_press, act_rel, act_long, act_tog;
    bit   sel = 1'b0;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int first_press, first_rel, first_long, n_press, n_rel, n_long;
    logic tog_log[$];
    exp_t exp_q[$];

    // reference model state
    logic         m_s1, m_s2, m_pressed, m_tog;
    logic [D-1:0] m_hist;
    int           m_lc;

    seg_t  segs [NSEG];
    scen_t scens[NSCEN];

    always #5 clk = ~clk;

    button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .BUTTON(button0),
        .PRESSED(p0), .PRESS(ps0), .RELEASE(r0), .LONG_PRESS(l0), .TOGGLE(t0)
    );

    button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .BUTTON(button1),
        .PRESSED(p1), .PRESS(ps1), .RELEASE(r1), .LONG_PRESS(l1), .TOGGLE(t1)
    );

    assign act_pressed = sel ? p1  : p0;
    assign act_press   = sel ? ps1 : ps0;
    assign act_rel     = sel ? r1  : r0;
    assign act_long    = sel ? l1  : l0;
    assign act_tog     = sel ? t1  : t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", name, ecount, act, req);
        end
    endtask

    task automatic clear_stats();
        first_press = -1; first_rel = -1; first_long = -1;
        n_press = 0; n_rel = 0; n_long = 0;
        tog_log.delete();
    endtask

    task automatic model_reset();
        m_s1 = sel; m_s2 = sel;
        m_hist = '0; m_pressed = 1'b0; m_tog = 1'b0; m_lc = 0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pressed0"}, p0, 0);  check({tag, "_press0"}, ps0, 0);
        check({tag, "_release0"}, r0, 0);  check({tag, "_long0"}, l0, 0);
        check({tag, "_toggle0"}, t0, 0);   check({tag, "_pressed1"}, p1, 0);
        check({tag, "_press1"}, ps1, 0);   check({tag, "_toggle1"}, t1, 0);
    endtask

    // Starts and ends on a falling edge.
    task automatic do_reset(input bit use1);
        @(negedge clk);
        button0 = 1'b0;
        button1 = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        sel = use1;
        model_reset();
        clear_stats();
        ecount = 0;
        rst_n = 1'b1;
    endtask

    // Drive at the falling edge, model the next rising edge, return at the next falling edge.
    task automatic step(input logic b);
        logic sync_now, old_p, pe, re, le;
        if (sel) button1 = b; else button0 = b;
        @(posedge clk);
        ecount++;
        sync_now = m_s2 ^ sel;
        m_s2 = m_s1;
        m_s1 = b;
        m_hist = {m_hist[D-2:0], sync_now};
        old_p = m_pressed;
        pe = 1'b0;
        re = 1'b0;
        if (!old_p && (m_hist == {D{1'b1}})) begin
            m_pressed = 1'b1; pe = 1'b1;
        end else if (old_p && (m_hist == {D{1'b0}})) begin
            m_pressed = 1'b0; re = 1'b1;
        end
        le = old_p && (m_lc == L - 1);
        if (pe || re) m_lc = 0;
        else if (old_p && m_lc < L) m_lc++;
        if (pe) m_tog = ~m_tog;
        exp_q.push_back('{m_pressed, pe, re, le, m_tog});
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pressed", act_pressed, e.pressed);
            check("press", act_press, e.press);
            check("release", act_rel, e.rel);
            check("long_press", act_long, e.lng);
            check("toggle", act_tog, e.tog);
            if (act_press === 1'b1) begin
                n_press++;
                if (first_press < 0) first_press = ecount;
                tog_log.push_back(act_tog);
                $display("edge %0d PRESS toggle=%0b", ecount, act_tog);
            end
            if (act_rel === 1'b1) begin
                n_rel++;
                if (first_rel < 0) first_rel = ecount;
                $display("edge %0d RELEASE", ecount);
            end
            if (act_long === 1'b1) begin
                n_long++;
                if (first_long < 0) first_long = ecount;
                $display("edge %0d LONG_PRESS", ecount);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // clean press; bounce on press and release; long hold; toggles; active-low pin
        segs[0]  = '{0, 1'b0, 9};   segs[1]  = '{0, 1'b1, 12};
        segs[2]  = '{1, 1'b0, 9};   segs[3]  = '{1, 1'b1, 3};   segs[4]  = '{1, 1'b0, 1};
        segs[5]  = '{1, 1'b1, 12};  segs[6]  = '{1, 1'b0, 2};   segs[7]  = '{1, 1'b1, 1};
        segs[8]  = '{1, 1'b0, 17};
        segs[9]  = '{2, 1'b0, 9};   segs[10] = '{2, 1'b1, 100}; segs[11] = '{2, 1'b0, 20};
        segs[12] = '{2, 1'b1, 10};  segs[13] = '{2, 1'b0, 10};  segs[14] = '{2, 1'b1, 10};
        segs[15] = '{2, 1'b0, 10};
        segs[16] = '{3, 1'b0, 9};   segs[17] = '{3, 1'b1, 8};   segs[18] = '{3, 1'b0, 8};
        segs[19] = '{3, 1'b1, 8};   segs[20] = '{3, 1'b0, 8};   segs[21] = '{3, 1'b1, 8};
        segs[22] = '{3, 1'b0, 8};
        segs[23] = '{4, 1'b1, 9};   segs[24] = '{4, 1'b0, 12};

        scens[0] = '{15, -1, -1, 1, 0, 0, 1'b0};
        scens[1] = '{19, 34, -1, 1, 1, 0, 1'b0};
        scens[2] = '{15, 115, 35, 3, 3, 1, 1'b0};
        scens[3] = '{15, 23, -1, 3, 3, 0, 1'b0};
        scens[4] = '{15, -1, -1, 1, 0, 0, 1'b1};

        repeat (2) @(negedge clk);
        for (int s = 0; s < NSCEN; s++) begin
            do_reset(scens[s].use1);
            for (int g = 0; g < NSEG; g++) begin
                if (segs[g].scen == s) begin
                    repeat (segs[g].n) step(segs[g].lvl);
                end
            end
            check($sformatf("s%0d_first_press", s), first_press, scens[s].first_press);
            check($sformatf("s%0d_first_release", s), first_rel, scens[s].first_rel);
            check($sformatf("s%0d_first_long", s), first_long, scens[s].first_long);
            check($sformatf("s%0d_n_press", s), n_press, scens[s].n_press);
            check($sformatf("s%0d_n_release", s), n_rel, scens[s].n_rel);
            check($sformatf("s%0d_n_long", s), n_long, scens[s].n_long);
            if (s == 3) begin
                check("toggle_log_len", tog_log.size(), 3);
                if (tog_log.size() == 3) begin
                    check("toggle_after_press1", tog_log[0], 1);
                    check("toggle_after_press2", tog_log[1], 0);
                    check("toggle_after_press3", tog_log[2], 1);
                end
            end
        end

        // Reset asserted mid-hold clears outputs without a clock edge.
        do_reset(1'b0);
        repeat (9) step(1'b0);
        repeat (10) step(1'b1);
        check("midhold_pressed_before", p0, 1);
        check("midhold_toggle_before", t0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        model_reset();
        clear_stats();
        ecount = 0;
        rst_n = 1'b1;
        // Button still held: first sampled at edge 1, accepted at edge 1+1+D.
        repeat (10) step(1'b1);
        check("held_through_reset_press_edge", first_press, 6);
        check("held_through_reset_n_press", n_press, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
